// File: rtl/pattern_seq_pkg.sv
// Shared constants and types for the VGA pattern sequencer.
// Holds 640x480@60 timing defaults, pattern-id sizing and the step helper.
package pattern_seq_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int V_ACTIVE     = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int CNT_W        = 10;
   localparam int PATTERN_ID_W = 3;
   localparam int NUM_PATTERNS = 8;

   typedef enum logic [1:0] {
      PEND_NONE,
      PEND_NEXT,
      PEND_PREV
   } pend_t;

   // Id width equals log2(NUM_PATTERNS), so wrap is plain modular arithmetic.
   function automatic logic [PATTERN_ID_W-1:0] step_id(
      input logic [PATTERN_ID_W-1:0] id,
      input pend_t                   dir
   );
      logic [PATTERN_ID_W-1:0] r;
      r = id;
      if (dir == PEND_NEXT) r = id + 1'b1;
      if (dir == PEND_PREV) r = id - 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, h/v counters, frame_start, raw syncs.
// Ports: clk, reset (sync, high) -> pix_tick, frame_start, hcount, vcount, video_on, hsync_raw, vsync_raw.
module vga_timing
   import pattern_seq_pkg::*;
#(
   parameter int PIX_DIV  = 2,
   parameter int H_ACT    = H_ACTIVE,
   parameter int H_FPORCH = H_FP,
   parameter int H_SW     = H_SYNC,
   parameter int H_BPORCH = H_BP,
   parameter int V_ACT    = V_ACTIVE,
   parameter int V_FPORCH = V_FP,
   parameter int V_SW     = V_SYNC,
   parameter int V_BPORCH = V_BP
) (
   input  logic             clk,
   input  logic             reset,
   output logic             pix_tick,
   output logic             frame_start,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             video_on,
   output logic             hsync_raw,
   output logic             vsync_raw
);

   localparam int H_TOT = H_ACT + H_FPORCH + H_SW + H_BPORCH;
   localparam int V_TOT = V_ACT + V_FPORCH + V_SW + V_BPORCH;
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACT);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACT);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACT + H_FPORCH);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FPORCH + H_SW);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACT + V_FPORCH);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FPORCH + V_SW);

   logic [DIV_W-1:0] div;
   logic             h_last;
   logic             v_last;

   always_ff @(posedge clk) begin
      if (reset)                div <= '0;
      else if (div == DIV_LAST) div <= '0;
      else                      div <= div + 1'b1;
   end

   // Gated by reset so the tick reads 0 while reset is held, even at PIX_DIV = 1.
   assign pix_tick = !reset && (div == DIV_LAST);
   assign h_last   = (hcount == H_LAST);
   assign v_last   = (vcount == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_tick) begin
         if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + 1'b1;
         end else begin
            hcount <= hcount + 1'b1;
         end
      end
   end

   assign frame_start = pix_tick && h_last && v_last;
   assign video_on    = (hcount < H_VIS) && (vcount < V_VIS);
   assign hsync_raw   = !((hcount >= HS_BEG) && (hcount < HS_END));
   assign vsync_raw   = !((vcount >= VS_BEG) && (vcount < VS_END));

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: VGA timing, pattern-id stepping, registered blanked rgb/syncs.
// Ports: clk, reset, next_req, prev_req, auto_en, rgb_in -> pattern_id, pix_x, pix_y,
// pix_tick, frame_start, rgb_out, hsync, vsync. Option macro: PATTERN_AUTO_CYCLE_EN.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int PIX_DIV            = 2,
   parameter int H_ACTIVE           = pattern_seq_pkg::H_ACTIVE,
   parameter int H_FP               = pattern_seq_pkg::H_FP,
   parameter int H_SYNC             = pattern_seq_pkg::H_SYNC,
   parameter int H_BP               = pattern_seq_pkg::H_BP,
   parameter int V_ACTIVE           = pattern_seq_pkg::V_ACTIVE,
   parameter int V_FP               = pattern_seq_pkg::V_FP,
   parameter int V_SYNC             = pattern_seq_pkg::V_SYNC,
   parameter int V_BP               = pattern_seq_pkg::V_BP,
   parameter int FRAMES_PER_PATTERN = 120
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    next_req,
   input  logic                    prev_req,
   input  logic                    auto_en,
   input  logic [2:0]              rgb_in,
   output logic [PATTERN_ID_W-1:0] pattern_id,
   output logic [CNT_W-1:0]        pix_x,
   output logic [CNT_W-1:0]        pix_y,
   output logic                    pix_tick,
   output logic                    frame_start,
   output logic [2:0]              rgb_out,
   output logic                    hsync,
   output logic                    vsync
);

   logic video_on;
   logic hsync_raw;
   logic vsync_raw;

   vga_timing #(
      .PIX_DIV  (PIX_DIV),
      .H_ACT    (H_ACTIVE),
      .H_FPORCH (H_FP),
      .H_SW     (H_SYNC),
      .H_BPORCH (H_BP),
      .V_ACT    (V_ACTIVE),
      .V_FPORCH (V_FP),
      .V_SW     (V_SYNC),
      .V_BPORCH (V_BP)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .pix_tick    (pix_tick),
      .frame_start (frame_start),
      .hcount      (pix_x),
      .vcount      (pix_y),
      .video_on    (video_on),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw)
   );

   pend_t                   pend_q;
   pend_t                   pend_d;
   pend_t                   req;
   logic [PATTERN_ID_W-1:0] id_d;

`ifdef PATTERN_AUTO_CYCLE_EN
   localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

   logic [FC_W-1:0] fcnt_q;
   logic [FC_W-1:0] fcnt_d;

   always_ff @(posedge clk) begin
      if (reset) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end
`else
   logic unused_auto_en;
   assign unused_auto_en = auto_en;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= PEND_NONE;
         pattern_id <= '0;
      end else begin
         pend_q     <= pend_d;
         pattern_id <= id_d;
      end
   end

   // This cycle's request overrides the stored one, so a request that
   // lands on the frame_start cycle is applied at that same boundary.
   always_comb begin
      req = pend_q;
      if (next_req && prev_req) req = PEND_NONE;
      else if (next_req)        req = PEND_NEXT;
      else if (prev_req)        req = PEND_PREV;
      pend_d = req;
      id_d   = pattern_id;
`ifdef PATTERN_AUTO_CYCLE_EN
      fcnt_d = fcnt_q;
`endif
      if (frame_start) begin
         pend_d = PEND_NONE;
         id_d   = step_id(pattern_id, req);
`ifdef PATTERN_AUTO_CYCLE_EN
         if (!auto_en || req != PEND_NONE) begin
            fcnt_d = '0;
         end else if (fcnt_q == FC_LAST) begin
            fcnt_d = '0;
            id_d   = step_id(pattern_id, PEND_NEXT);
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
`endif
      end
   end

   // One pixel of latency keeps colour and both syncs aligned at the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_out <= '0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
      end else if (pix_tick) begin
         rgb_out <= video_on ? rgb_in : 3'b000;
         hsync   <= hsync_raw;
         vsync   <= vsync_raw;
      end
   end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Drives the 640x480 test-pattern generator and sequences its pattern selection.
- Produces VGA 640x480@60 timing: pixel-tick enable, pixel coordinates, sync pulses.
- Holds the 3-bit pattern id. Steps it on user next/prev requests, and optionally auto-advances every N frames.
- Registers the generator's combinational rgb with blanking applied, so rgb and both syncs leave the block aligned.
- Sits between the board button debouncers and the VGA connector, around the pattern generator.

Parameters:
PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate); must be >= 1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch; line total 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch; frame total 525
FRAMES_PER_PATTERN, 120, frames per pattern in auto mode (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
next_req  in  1  one-clk pulse (debounced upstream): advance pattern
prev_req  in  1  one-clk pulse: step pattern back
auto_en  in  1  enable auto-advance (ignored unless feature compiled in)
rgb_in  in  3  combinational colour from the pattern generator for the current pix_x/pix_y/pattern_id
pattern_id  out  3  pattern select to the generator
pix_x  out  10  current horizontal count 0..799
pix_y  out  10  current vertical count 0..524
pix_tick  out  1  one-clk pixel enable
frame_start  out  1  one-clk pulse on the tick where the counters wrap to (0,0)
rgb_out  out  3  registered, blanked colour to the DAC/pins
hsync  out  1  registered, active-low
vsync  out  1  registered, active-low

Behaviour:
Reset values (same cycle reset is seen at a clk edge):
- All counters 0; pattern_id = 0; pending request cleared.
- pix_tick = 0, frame_start = 0, rgb_out = 0.
- hsync = 1, vsync = 1.
- Reset mid-frame restarts timing at (0,0); any pending request is discarded.

Pixel tick:
- Divider counts 0..PIX_DIV-1; pix_tick = 1 when divider == PIX_DIV-1.
- With PIX_DIV = 1, pix_tick is constantly 1 after reset.

Counters (advance only on pix_tick):
- hcount wraps 799->0; on that wrap vcount increments, and vcount wraps 524->0.
- pix_x = hcount, pix_y = vcount.
- frame_start = pix_tick && hcount == 799 && vcount == 524, i.e. asserted the cycle the counters step to (0,0).

Output stage (updates on pix_tick only, 1 pixel of latency relative to pix_x/pix_y):
- video_on = hcount < 640 && vcount < 480.
- rgb_out <= video_on ? rgb_in : 0.
- hsync <= !(656 <= hcount < 752).
- vsync <= !(490 <= vcount < 492).

Requests:
- next_req / prev_req set a pending direction register; the latest request wins.
- next_req and prev_req in the same cycle: pending is cleared, no change.
- Requests are accepted in any cycle, including the frame_start cycle. The request edge seen on frame_start is applied at that boundary.

Pattern update (only on the frame_start cycle, so the id never changes mid-frame):
- pending next: id + 1, wrapping 7->0.
- pending prev: id - 1, wrapping 0->7.
- Then clear pending and reset frame_cnt to 0.

Optional Feature:
Macro PATTERN_AUTO_CYCLE_EN.
- Defined:
  - frame_cnt (width clog2(FRAMES_PER_PATTERN)) increments on each frame_start while auto_en = 1.
  - On a frame_start with frame_cnt == FRAMES_PER_PATTERN-1 and nothing pending: id + 1 (wrapping), frame_cnt <= 0.
  - A pending manual request at the same frame_start takes priority; frame_cnt still resets.
  - auto_en = 0 holds frame_cnt at 0.
- Undefined: no frame counter; auto_en is unconnected internally; only manual stepping.

Decomposition:
- Package pattern_seq_pkg: timing constants (H_TOTAL = 800, V_TOTAL = 525, sync start/end values), PATTERN_ID_W = 3, NUM_PATTERNS = 8.
- One sub-module, vga_timing: pixel divider, hcount/vcount, pix_tick, frame_start, video_on, raw syncs.
- The top level keeps the request/id logic and the output register stage.

Test Plan:
1. Reset, then run 2 frames with PIX_DIV = 2 -> frame_start every 840000 clk; hsync low for 192 clk per line starting at hcount 656 (+1 tick registered); vsync low for lines 490-491.
2. rgb_in tied to 3'b101 -> rgb_out = 101 only where the previous tick's hcount < 640 and vcount < 480; rgb_out = 0 throughout blanking.
3. next_req pulse at (100,200) -> pattern_id stays 0 until frame_start, then becomes 1. Three prev_req pulses in three separate frames from id 1 -> 0, 7, 6.
4. next_req and prev_req asserted in the same cycle -> no id change at the next frame_start. next_req then prev_req in one frame -> id - 1 at the boundary.
5. PATTERN_AUTO_CYCLE_EN, FRAMES_PER_PATTERN = 3, auto_en = 1 -> id advances every 3rd frame_start (0->1->2...), 7->0 wrap. next_req during frame 2 -> id + 1 at the next boundary and the 3-frame count restarts.
6. reset asserted at (300,300) with a pending request -> next cycle counters 0, id 0, hsync = vsync = 1; the request is not applied.
